// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO edge-interrupt block: register word
// indices, the bus data width and the debounce counter width.
package gpio_pkg;

  // Register word indices, decoded from byte address bits [3:2]
  typedef enum logic [1:0] {
    IDX_IN      = 2'd0,
    IDX_RISE_EN = 2'd1,
    IDX_FALL_EN = 2'd2,
    IDX_STATUS  = 2'd3
  } reg_idx_t;

  localparam int unsigned REG_W = 32;

  // Counter width: wide enough for DEBOUNCE_CYCLES up to 255
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin front end: two-flop synchroniser followed by a stable-count
// debouncer. Emits the accepted level plus one-cycle rise/fall pulses
// aligned with the cycle the accepted level changes.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             synced;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The change is accepted on the cycle the counter would reach DEBOUNCE_CYCLES
  assign accept = (synced != level) && (cnt == LAST_CNT);

  // Two-flop synchroniser for the asynchronous pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= pad;
      synced <= meta;
    end
  end

  // Count consecutive cycles the synced value differs from the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (synced != level) begin
      if (accept) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // One-cycle edge pulses, high while the new level is first visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept && synced;
      fall <= accept && !synced;
    end
  end

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO edge-interrupt controller: per-pin synchronise/debounce, rising and
// falling edge enables, sticky write-1-to-clear status and a registered
// level interrupt, accessed through a simple strobe-based register port.
module gpio_edge_irq
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [1:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic                  reg_rd_valid,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] level;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] rise_en;
  logic [GPIO_WIDTH-1:0] fall_en;
  logic [GPIO_WIDTH-1:0] status;
  logic [GPIO_WIDTH-1:0] wdata_pins;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic [GPIO_WIDTH-1:0] edge_set;
  logic [REG_W-1:0]      rd_word;
  logic                  wr_rise_en;
  logic                  wr_fall_en;
  logic                  wr_status;
  logic                  unused_wdata;

  // Bits of reg_wdata above GPIO_WIDTH are deliberately dropped
  assign unused_wdata = ^reg_wdata;

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (s00_axi_aclk),
      .rst_n(s00_axi_aresetn),
      .pad  (gpio_in[g]),
      .level(level[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  assign wdata_pins = reg_wdata[GPIO_WIDTH-1:0];
  assign wr_rise_en = reg_wr_en && (reg_addr == IDX_RISE_EN);
  assign wr_fall_en = reg_wr_en && (reg_addr == IDX_FALL_EN);
  assign wr_status  = reg_wr_en && (reg_addr == IDX_STATUS);
  assign w1c_mask   = wr_status ? wdata_pins : '0;

  // Only edges whose enable is set at detection time are ever recorded
  assign edge_set = (rise & rise_en) | (fall & fall_en);

  // Edge enable registers
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      if (wr_rise_en) rise_en <= wdata_pins;
      if (wr_fall_en) fall_en <= wdata_pins;
    end
  end

  // Sticky status: clear first, then set, so a coincident new edge wins
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      status <= '0;
    end else begin
      status <= (status & ~w1c_mask) | edge_set;
    end
  end

  // Registered level interrupt following any pending status bit
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |status;
    end
  end

  // Read mux over current (pre-write) register contents, zero-extended
  always_comb begin
    rd_word = '0;
    case (reg_addr)
      IDX_IN:      rd_word = REG_W'(level);
      IDX_RISE_EN: rd_word = REG_W'(rise_en);
      IDX_FALL_EN: rd_word = REG_W'(fall_en);
      IDX_STATUS:  rd_word = REG_W'(status);
      default:     rd_word = '0;
    endcase
  end

  // Registered read response; data is forced to zero outside the valid cycle
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      reg_rd_valid <= 1'b0;
      reg_rdata    <= '0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      reg_rdata    <= reg_rd_en ? rd_word : '0;
    end
  end

endmodule

// File: doc/gpio_edge_irq.md
GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 8, number of input pins (legal range 1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a pin change (legal range 1..255).
REQ-003 SHALL have port s00_axi_aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port s00_axi_aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port gpio_in  input  GPIO_WIDTH  asynchronous pad inputs.
REQ-006 SHALL have port reg_wr_en  input  1  single-cycle write strobe from the AXI4-Lite slave register stage.
REQ-007 SHALL have port reg_rd_en  input  1  single-cycle read strobe.
REQ-008 SHALL have port reg_addr  input  2  word index (byte address bits [3:2]).
REQ-009 SHALL have port reg_wdata  input  32  write data.
REQ-010 SHALL have port reg_rdata  output  32  read data, valid when reg_rd_valid is high.
REQ-011 SHALL have port reg_rd_valid  output  1  one-cycle pulse, one cycle after reg_rd_en.
REQ-012 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-013 SHALL synchronise each gpio_in bit through two flip-flops before any other use.
REQ-014 SHALL hold, per bit, a debounced value and a counter; counter increments while synced bit differs from debounced value, clears when equal.
REQ-015 SHALL update the debounced bit and clear its counter on the cycle the counter would reach DEBOUNCE_CYCLES; a glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) SHALL never change the debounced value.
REQ-016 SHALL detect a rising (0->1) or falling (1->0) debounced transition and, if the matching RISE_EN/FALL_EN bit is set, set the STATUS bit on the next clock.
REQ-017 SHALL map registers: index 0 IN (RO, debounced value), 1 RISE_EN (RW), 2 FALL_EN (RW), 3 STATUS (read; write-1-to-clear).
REQ-018 SHALL ignore writes to IN; bits above GPIO_WIDTH SHALL read 0 and be ignored on write.
REQ-019 SHALL return reg_rdata registered, one cycle after reg_rd_en, with reg_rd_valid high for exactly that cycle; reg_rdata SHALL be 0 when reg_rd_valid is low.
REQ-020 SHALL give priority to a new edge over a W1C of the same STATUS bit in the same cycle (bit stays set).
REQ-021 SHALL accept reg_wr_en and reg_rd_en in the same cycle; a read of STATUS then returns the pre-write value.
REQ-022 SHALL drive irq high on the clock after any STATUS bit is set and low on the clock after STATUS becomes all-zero.
REQ-023 SHALL not set STATUS for an edge whose enable bit is clear, even if enabled later.
REQ-024 SHALL total pad-to-STATUS latency of 2 + DEBOUNCE_CYCLES + 1 cycles for a clean step.

Reset
REQ-025 SHALL clear asynchronously on s00_axi_aresetn low: sync flops, debounced values, counters, RISE_EN, FALL_EN, STATUS, reg_rdata, reg_rd_valid, irq all to 0.
REQ-026 SHALL abandon any in-progress debounce on reset mid-operation; a pin held high through reset release SHALL be reported as a rising edge after the REQ-024 latency if RISE_EN is set.

Structure
REQ-027 SHALL place register index constants (IDX_IN, IDX_RISE_EN, IDX_FALL_EN, IDX_STATUS) in shared package gpio_pkg.
REQ-028 SHALL implement per-bit synchroniser and debounce in sub-module gpio_debounce, instantiated GPIO_WIDTH times.

Verification
REQ-029 SHALL verify: reset, read all 4 indices -> 0x00000000 each, irq 0.
REQ-030 SHALL verify: RISE_EN=0x01, gpio_in[0] 0->1 held -> STATUS=0x01 at cycle 7 (DEBOUNCE_CYCLES=4), irq high at cycle 8; IN reads 0x01.
REQ-031 SHALL verify: 3-cycle pulse on gpio_in[1] with RISE_EN=FALL_EN=0xFF -> IN unchanged 0x00, STATUS 0x00, irq never asserted.
REQ-032 SHALL verify: STATUS=0x03, write 0x01 to index 3 -> STATUS=0x02, irq stays high; write 0x02 -> STATUS 0x00, irq low next cycle.
REQ-033 SHALL verify: W1C of bit 2 in same cycle as new falling edge on bit 2 (FALL_EN=0x04) -> STATUS bit 2 remains 1.
REQ-034 SHALL verify: s00_axi_aresetn pulsed low mid-debounce with RISE_EN=0x80 -> all registers 0; gpio_in[7] held high after release -> STATUS=0x80 after 7 cycles.
